// File: rtl/int_sched.sv
// Interrupt scheduler: per-source edge/level capture, fixed-priority selection
// and a three-state request/service handshake towards CP0.
module int_sched (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] hw_in,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic       cfg_we,
   input  logic [5:0] cfg_edge,
   input  logic       ack,
   input  logic       eret,
   output logic       irq_req,
   output logic [2:0] irq_id,
   output logic [5:0] ip,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t     state_q;
   logic [5:0] hw_q;
   logic [5:0] cfg_q, cfg_d;
   logic [5:0] edge_pend_q, edge_pend_d;
   logic       irq_req_q;
   logic       busy_q;
   logic [2:0] irq_id_q;

   logic [5:0] rise;
   logic [5:0] pend;
   logic [5:0] eligible;
   logic [2:0] winner;
   logic       any_elig;
   logic       ack_take;

   always_comb begin
      rise     = hw_in & ~hw_q;
      // Level sources mirror the registered input; edge sources use the latch.
      pend     = (edge_pend_q & cfg_q) | (hw_q & ~cfg_q);
      eligible = pend & im & {6{ie & ~exl}};
      any_elig = |eligible;

      winner = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (eligible[i]) winner = 3'(i);
      end

      ack_take    = (state_q == REQ) && ack;
      edge_pend_d = edge_pend_q;
      if (ack_take) edge_pend_d[irq_id_q] = 1'b0;
      // Set after clear so a coincident new edge keeps the source pending.
      edge_pend_d = (edge_pend_d | rise) & cfg_q;

      cfg_d = cfg_q;
      if (cfg_we) begin
         cfg_d       = cfg_edge;
         edge_pend_d = edge_pend_d & cfg_edge;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         hw_q        <= 6'd0;
         cfg_q       <= 6'd0;
         edge_pend_q <= 6'd0;
         irq_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         irq_id_q    <= 3'd0;
      end else begin
         hw_q        <= hw_in;
         cfg_q       <= cfg_d;
         edge_pend_q <= edge_pend_d;
         case (state_q)
            IDLE: begin
               if (any_elig) begin
                  state_q   <= REQ;
                  irq_id_q  <= winner;
                  irq_req_q <= 1'b1;
               end
            end
            REQ: begin
               // Ack takes precedence over a same-cycle withdrawal.
               if (ack) begin
                  state_q   <= SERVICE;
                  irq_req_q <= 1'b0;
                  busy_q    <= 1'b1;
               end else if (!eligible[irq_id_q]) begin
                  state_q   <= IDLE;
                  irq_req_q <= 1'b0;
               end
            end
            SERVICE: begin
               if (eret) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               irq_req_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req = irq_req_q;
   assign irq_id  = irq_id_q;
   assign ip      = pend;
   assign busy    = busy_q;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: hand-computed expectations checked after each edge.
module tb_int_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] hw_in;
   logic [5:0] im;
   logic       ie;
   logic       exl;
   logic       cfg_we;
   logic [5:0] cfg_edge;
   logic       ack;
   logic       eret;
   logic       irq_req;
   logic [2:0] irq_id;
   logic [5:0] ip;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   int_sched dut (
      .clk      (clk),
      .reset    (reset),
      .hw_in    (hw_in),
      .im       (im),
      .ie       (ie),
      .exl      (exl),
      .cfg_we   (cfg_we),
      .cfg_edge (cfg_edge),
      .ack      (ack),
      .eret     (eret),
      .irq_req  (irq_req),
      .irq_id   (irq_id),
      .ip       (ip),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; hw_in = 6'h00; im = 6'h00; ie = 1'b0; exl = 1'b0;
      cfg_we = 1'b0; cfg_edge = 6'h00; ack = 1'b0; eret = 1'b0;
      tick(); tick();
      chk("rst_irq_req", {7'd0, irq_req}, 8'h00);
      chk("rst_irq_id",  {5'd0, irq_id},  8'h00);
      chk("rst_ip",      {2'd0, ip},      8'h00);
      chk("rst_busy",    {7'd0, busy},    8'h00);

      // Source 0 in edge mode, everything enabled.
      reset = 1'b1; im = 6'h3F; ie = 1'b1;
      cfg_we = 1'b1; cfg_edge = 6'h01; tick(); cfg_we = 1'b0;
      hw_in = 6'h01; tick();
      chk("edge_ip_n1",   {2'd0, ip}, 8'h01);
      chk("edge_req_n1",  {7'd0, irq_req}, 8'h00);
      tick();
      chk("edge_req_n2",  {7'd0, irq_req}, 8'h01);
      chk("edge_id_n2",   {5'd0, irq_id}, 8'h00);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("edge_ack_busy", {7'd0, busy}, 8'h01);
      chk("edge_ack_req",  {7'd0, irq_req}, 8'h00);
      chk("edge_ack_clr",  {2'd0, ip}, 8'h00);
      eret = 1'b1; tick(); eret = 1'b0;
      chk("edge_eret_busy", {7'd0, busy}, 8'h00);
      hw_in = 6'h00; tick();
      ack = 1'b1; tick(); ack = 1'b0;
      chk("stray_ack_busy", {7'd0, busy}, 8'h00);

      // Ack coincident with a new rising edge keeps the source pending.
      hw_in = 6'h01; tick(); tick();
      chk("coinc_req", {7'd0, irq_req}, 8'h01);
      hw_in = 6'h00; tick();
      chk("coinc_hold_req", {7'd0, irq_req}, 8'h01);
      hw_in = 6'h01; ack = 1'b1; tick(); ack = 1'b0;
      chk("coinc_busy", {7'd0, busy}, 8'h01);
      chk("coinc_ip",   {2'd0, ip},   8'h01);
      eret = 1'b1; tick(); eret = 1'b0;
      tick();
      chk("coinc_rereq", {7'd0, irq_req}, 8'h01);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("coinc_ip_clr", {2'd0, ip}, 8'h00);
      eret = 1'b1; hw_in = 6'h00; tick(); eret = 1'b0;

      // All sources level; sources 0 and 2 active.
      cfg_we = 1'b1; cfg_edge = 6'h00; tick(); cfg_we = 1'b0;
      hw_in = 6'h05; tick();
      chk("lvl_ip", {2'd0, ip}, 8'h05);
      tick();
      chk("lvl_req", {7'd0, irq_req}, 8'h01);
      chk("lvl_id",  {5'd0, irq_id},  8'h02);
      hw_in = 6'h25; tick(); tick();
      chk("nopreempt_id", {5'd0, irq_id}, 8'h02);
      chk("nopreempt_ip", {2'd0, ip}, 8'h25);
      hw_in = 6'h05;
      ack = 1'b1; tick(); ack = 1'b0;
      chk("lvl_ack_busy", {7'd0, busy}, 8'h01);
      chk("lvl_ack_req",  {7'd0, irq_req}, 8'h00);
      eret = 1'b1; tick(); eret = 1'b0;
      chk("lvl_eret_busy", {7'd0, busy}, 8'h00);
      tick();
      chk("lvl_rereq",    {7'd0, irq_req}, 8'h01);
      chk("lvl_rereq_id", {5'd0, irq_id},  8'h02);
      ack = 1'b1; hw_in = 6'h00; tick(); ack = 1'b0;
      eret = 1'b1; tick(); eret = 1'b0;
      tick();
      chk("lvl_idle_ip",  {2'd0, ip}, 8'h00);
      chk("lvl_idle_req", {7'd0, irq_req}, 8'h00);

      // Level source 1 withdraws before ack.
      hw_in = 6'h02; tick(); tick();
      chk("wd_req", {7'd0, irq_req}, 8'h01);
      chk("wd_id",  {5'd0, irq_id},  8'h01);
      hw_in = 6'h00; tick();
      chk("wd_ip", {2'd0, ip}, 8'h00);
      tick();
      chk("wd_req_drop", {7'd0, irq_req}, 8'h00);
      chk("wd_busy",     {7'd0, busy},    8'h00);

      // Exception level gates requests.
      exl = 1'b1; hw_in = 6'h04; tick();
      chk("exl_ip", {2'd0, ip}, 8'h04);
      tick(); tick();
      chk("exl_block", {7'd0, irq_req}, 8'h00);
      exl = 1'b0; tick();
      chk("exl_release_req", {7'd0, irq_req}, 8'h01);
      chk("exl_release_id",  {5'd0, irq_id},  8'h02);
      exl = 1'b1; tick(); exl = 1'b0;
      chk("exl_abort_req", {7'd0, irq_req}, 8'h00);
      tick();
      chk("exl_rereq", {7'd0, irq_req}, 8'h01);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("svc_busy", {7'd0, busy}, 8'h01);

      // Config write while servicing leaves FSM alone; reset then aborts.
      cfg_we = 1'b1; cfg_edge = 6'h3F; tick(); cfg_we = 1'b0;
      chk("cfg_svc_busy", {7'd0, busy}, 8'h01);
      chk("cfg_svc_id",   {5'd0, irq_id}, 8'h02);
      reset = 1'b0; tick();
      chk("rst_svc_req",  {7'd0, irq_req}, 8'h00);
      chk("rst_svc_busy", {7'd0, busy}, 8'h00);
      chk("rst_svc_ip",   {2'd0, ip}, 8'h00);
      reset = 1'b1; hw_in = 6'h00; tick();
      hw_in = 6'h04; tick();
      chk("post_rst_ip_hi", {2'd0, ip}, 8'h04);
      hw_in = 6'h00; tick();
      chk("post_rst_level", {2'd0, ip}, 8'h00);
      tick();
      chk("post_rst_req", {7'd0, irq_req}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-003 SHALL provide: hw_in  in  6  hardware interrupt sources; [0]=timer0, [1]=timer1, [2]=external, [5:3] spare.
REQ-004 SHALL provide: im  in  6  per-source mask from CP0 SR; 1=enabled.
REQ-005 SHALL provide: ie  in  1  global interrupt enable.
REQ-006 SHALL provide: exl  in  1  exception level; 1 blocks new requests.
REQ-007 SHALL provide: cfg_we  in  1  write strobe for cfg_edge.
REQ-008 SHALL provide: cfg_edge  in  6  per-source mode; 1=rising-edge latched, 0=level.
REQ-009 SHALL provide: ack  in  1  one-cycle pulse; CPU has taken the interrupt.
REQ-010 SHALL provide: eret  in  1  one-cycle pulse; handler finished.
REQ-011 SHALL provide: irq_req  out  1  registered interrupt request to CP0.
REQ-012 SHALL provide: irq_id  out  3  index of requesting source; valid while irq_req=1 or state=SERVICE.
REQ-013 SHALL provide: ip  out  6  pending vector for CP0 Cause.IP.
REQ-014 SHALL provide: busy  out  1  1 while state=SERVICE.

Function
REQ-015 SHALL register hw_in once (hw_q) for edge detection; rising edge = hw_in & ~hw_q.
REQ-016 SHALL, for edge-mode source i, set pend[i] on rising edge; clear only on ack with irq_id=i.
REQ-017 SHALL, for level-mode source i, set pend[i] = hw_q[i] each cycle (no latch).
REQ-018 SHALL drive ip = pend, combinationally from registers.
REQ-019 SHALL define eligible = pend & im, qualified by ie=1 and exl=0.
REQ-020 SHALL grant fixed priority: highest eligible index wins (5 highest, 0 lowest).
REQ-021 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-022 IDLE: if eligible non-empty -> REQ; irq_id latched to winner; irq_req=1 from next cycle.
REQ-023 REQ: irq_id frozen, irq_req held 1 until ack; higher-priority arrivals do not preempt.
REQ-024 REQ: if pend[irq_id]=0, or im[irq_id]/ie drops, or exl rises, before ack -> IDLE; irq_req=0 next cycle.
REQ-025 REQ with ack=1 -> SERVICE; irq_req=0 next cycle; edge pend[irq_id] cleared.
REQ-026 SERVICE: no new request; eret=1 -> IDLE; irq_id held until then.
REQ-027 Latency: hw_in edge at cycle N -> pend at N+1 (after hw_q) -> irq_req at N+2 (edge mode, idle, enabled).
REQ-028 Same-cycle ack clear and new rising edge on same source: set wins, pend stays 1.
REQ-029 ack outside REQ and eret outside SERVICE SHALL be ignored.
REQ-030 cfg_we SHALL load cfg_edge at clock edge; effective next cycle; sources switched to level drop latched pend.
REQ-031 cfg_we during REQ/SERVICE SHALL not alter FSM state or irq_id.

Reset
REQ-032 reset=0 SHALL give: state=IDLE, hw_q=0, pend=0, cfg_edge reg=0 (all level), irq_req=0, irq_id=0, ip=0, busy=0.
REQ-033 reset=0 mid-REQ/SERVICE SHALL abort at next edge to reset values; no ack needed.
REQ-034 Sources high at reset release SHALL not register edges that cycle (hw_q reset to 0 treats them as edges next cycle; documented, intended).

Verification
REQ-035 Edge mode src0, im=6'h3F, ie=1, exl=0: hw_in[0] rises cycle 10 -> ip=6'h01 at 11, irq_req=1, irq_id=0 at 12.
REQ-036 hw_in=6'b000101 level, all enabled -> irq_id=2; ack -> busy=1, irq_req=0; eret -> IDLE; pend[2] still 1 -> irq_req=1 again 1 cycle later.
REQ-037 Level src1 in REQ, hw_in[1] drops before ack -> irq_req=0 next cycle, state=IDLE, busy=0.
REQ-038 Edge src0 in REQ, ack coincident with new rising edge on hw_in[0] -> SERVICE, ip[0] stays 1.
REQ-039 exl=1 with ip=6'h04, im=6'h3F -> irq_req stays 0; exl falls -> irq_req=1 after 1 cycle.
REQ-040 reset=0 asserted during SERVICE -> next cycle irq_req=0, busy=0, ip=0, cfg reverts to level.
